// File: rtl/regfile_scoreboard_if.sv
// Decode/issue, operand and write-back signals between decode, the register file and execute.
// The master modport is the decode/write-back side; the slave modport is the register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             dec_valid_i;
  logic             dec_ready_o;
  logic [AW-1:0]    rs1_i;
  logic [AW-1:0]    rs2_i;
  logic [AW-1:0]    rd_i;
  logic             rd_we_i;
  logic [XLEN-1:0]  ra_o;
  logic [XLEN-1:0]  rb_o;
  logic             op_valid_o;
  logic [AW-1:0]    op_rd_o;
  logic             wb_valid_i;
  logic [AW-1:0]    wb_rd_i;
  logic [XLEN-1:0]  wb_data_i;
  logic [NREGS-1:0] busy_o;

  modport master (
    output dec_valid_i, rs1_i, rs2_i, rd_i, rd_we_i, wb_valid_i, wb_rd_i, wb_data_i,
    input  dec_ready_o, ra_o, rb_o, op_valid_o, op_rd_o, busy_o
  );

  modport slave (
    input  dec_valid_i, rs1_i, rs2_i, rd_i, rd_we_i, wb_valid_i, wb_rd_i, wb_data_i,
    output dec_ready_o, ra_o, rb_o, op_valid_o, op_rd_o, busy_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy bits; stalls decode on RAW/WAW hazards
// and hands registered operands to execute one cycle after issue.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic               clk,
  input logic               reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  ra_p0, rb_p0, ra_p1, rb_p1;
  logic [AW-1:0]    rd_p0, rd_p1;
  logic             vld_p0, vld_p1;
  logic             ready_p0;
  logic             hit1, hit2, hitd;
  logic             src1_ok, src2_ok, rd_ok;

  function automatic logic in_range(input logic [AW-1:0] r);
    return 32'(r) < 32'(NREGS);
  endfunction

  function automatic logic is_busy(input logic [AW-1:0] r, input logic [NREGS-1:0] b);
    return in_range(r) && b[r];
  endfunction

  function automatic logic wb_hit(input logic [AW-1:0] r, input logic wv, input logic [AW-1:0] wrd);
    return wv && (wrd == r) && (r != '0);
  endfunction

  function automatic logic [XLEN-1:0] read_val(input logic [AW-1:0] r, input logic h,
                                               input logic [XLEN-1:0] wdata,
                                               input logic [XLEN-1:0] mem);
    if ((r == '0) || !in_range(r)) return '0;
    if (BYPASS && h) return wdata;
    return mem;
  endfunction

  // p0: hazard check, operand read, scoreboard next state
  always_comb begin
    hit1     = wb_hit(bus.rs1_i, bus.wb_valid_i, bus.wb_rd_i);
    hit2     = wb_hit(bus.rs2_i, bus.wb_valid_i, bus.wb_rd_i);
    hitd     = wb_hit(bus.rd_i,  bus.wb_valid_i, bus.wb_rd_i);
    src1_ok  = (bus.rs1_i == '0) || !is_busy(bus.rs1_i, busy_q) || (BYPASS && hit1);
    src2_ok  = (bus.rs2_i == '0) || !is_busy(bus.rs2_i, busy_q) || (BYPASS && hit2);
    // A same-cycle write-back to rd releases the WAW hazard even without bypass.
    rd_ok    = !bus.rd_we_i || (bus.rd_i == '0) || !is_busy(bus.rd_i, busy_q) || hitd;
    ready_p0 = src1_ok && src2_ok && rd_ok;
    vld_p0   = bus.dec_valid_i && ready_p0;
    ra_p0    = read_val(bus.rs1_i, hit1, bus.wb_data_i, regs[bus.rs1_i]);
    rb_p0    = read_val(bus.rs2_i, hit2, bus.wb_data_i, regs[bus.rs2_i]);
    rd_p0    = bus.rd_we_i ? bus.rd_i : '0;

    busy_d = busy_q;
    if (bus.wb_valid_i && in_range(bus.wb_rd_i))
      busy_d[bus.wb_rd_i] = 1'b0;
    // Set after clear so a same-cycle issue keeps the register pending.
    if (vld_p0 && bus.rd_we_i && (bus.rd_i != '0) && in_range(bus.rd_i))
      busy_d[bus.rd_i] = 1'b1;
  end

  // p1: architectural state and registered operands toward execute
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy_q <= '0;
      ra_p1  <= '0;
      rb_p1  <= '0;
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (bus.wb_valid_i && (bus.wb_rd_i != '0) && in_range(bus.wb_rd_i))
        regs[bus.wb_rd_i] <= bus.wb_data_i;
      busy_q <= busy_d;
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        ra_p1 <= ra_p0;
        rb_p1 <= rb_p0;
        rd_p1 <= rd_p0;
      end
    end
  end

  assign bus.dec_ready_o = ready_p0;
  assign bus.ra_o        = ra_p1;
  assign bus.rb_o        = rb_p1;
  assign bus.op_rd_o     = rd_p1;
  assign bus.op_valid_o  = vld_p1;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, no-bypass and narrow configurations.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) ifa ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) ifb ();
  regfile_scoreboard_if #(.XLEN(16), .NREGS(8))  ifc ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  regfile_scoreboard #(.XLEN(16), .NREGS(8),  .BYPASS(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.dec_valid_i = 0; ifa.rs1_i = 0; ifa.rs2_i = 0; ifa.rd_i = 0; ifa.rd_we_i = 0;
    ifa.wb_valid_i = 0; ifa.wb_rd_i = 0; ifa.wb_data_i = 0;
    ifb.dec_valid_i = 0; ifb.rs1_i = 0; ifb.rs2_i = 0; ifb.rd_i = 0; ifb.rd_we_i = 0;
    ifb.wb_valid_i = 0; ifb.wb_rd_i = 0; ifb.wb_data_i = 0;
    ifc.dec_valid_i = 0; ifc.rs1_i = 0; ifc.rs2_i = 0; ifc.rd_i = 0; ifc.rd_we_i = 0;
    ifc.wb_valid_i = 0; ifc.wb_rd_i = 0; ifc.wb_data_i = 0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1; tick(); tick();
    reset = 0;
    n_checks++; if (ifa.busy_o !== 32'h0) $display("FAIL reset_busy got %h want 0", ifa.busy_o); else n_pass++;
    n_checks++; if (ifa.op_valid_o !== 1'b0) $display("FAIL reset_opvalid got %b want 0", ifa.op_valid_o); else n_pass++;
    n_checks++; if (ifa.ra_o !== 32'h0 || ifa.rb_o !== 32'h0) $display("FAIL reset_operands got %h/%h want 0/0", ifa.ra_o, ifa.rb_o); else n_pass++;
    n_checks++; if (ifa.op_rd_o !== 5'd0) $display("FAIL reset_oprd got %0d want 0", ifa.op_rd_o); else n_pass++;
    n_checks++; if (ifa.dec_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ifa.dec_ready_o); else n_pass++;
    n_checks++; if (ifb.dec_ready_o !== 1'b1 || ifc.dec_ready_o !== 1'b1) $display("FAIL reset_ready_bc got %b%b want 11", ifb.dec_ready_o, ifc.dec_ready_o); else n_pass++;
  endtask

  task automatic test_r0_write();
    ifa.wb_valid_i = 1; ifa.wb_rd_i = 0; ifa.wb_data_i = 32'hDEADBEEF;
    tick();
    ifa.wb_valid_i = 0;
    ifa.dec_valid_i = 1; ifa.rs1_i = 0; ifa.rs2_i = 5; ifa.rd_we_i = 0;
    #1;
    n_checks++; if (ifa.dec_ready_o !== 1'b1) $display("FAIL r0_ready got %b want 1", ifa.dec_ready_o); else n_pass++;
    tick();
    ifa.dec_valid_i = 0;
    n_checks++; if (ifa.op_valid_o !== 1'b1) $display("FAIL r0_opvalid got %b want 1", ifa.op_valid_o); else n_pass++;
    n_checks++; if (ifa.ra_o !== 32'h0 || ifa.rb_o !== 32'h0) $display("FAIL r0_operands got %h/%h want 0/0", ifa.ra_o, ifa.rb_o); else n_pass++;
    n_checks++; if (ifa.busy_o !== 32'h0) $display("FAIL r0_busy got %h want 0", ifa.busy_o); else n_pass++;
    tick();
    n_checks++; if (ifa.op_valid_o !== 1'b0) $display("FAIL r0_pulse got %b want 0", ifa.op_valid_o); else n_pass++;
  endtask

  task automatic test_raw_bypass();
    ifa.dec_valid_i = 1; ifa.rs1_i = 0; ifa.rs2_i = 0; ifa.rd_i = 3; ifa.rd_we_i = 1;
    tick();
    n_checks++; if (ifa.busy_o !== 32'h8) $display("FAIL byp_busy_set got %h want 00000008", ifa.busy_o); else n_pass++;
    ifa.rs1_i = 3; ifa.rd_i = 0; ifa.rd_we_i = 0;
    #1;
    n_checks++; if (ifa.dec_ready_o !== 1'b0) $display("FAIL byp_stall got %b want 0", ifa.dec_ready_o); else n_pass++;
    tick();
    n_checks++; if (ifa.op_valid_o !== 1'b0) $display("FAIL byp_no_issue got %b want 0", ifa.op_valid_o); else n_pass++;
    ifa.wb_valid_i = 1; ifa.wb_rd_i = 3; ifa.wb_data_i = 32'h1234;
    #1;
    n_checks++; if (ifa.dec_ready_o !== 1'b1) $display("FAIL byp_ready_on_wb got %b want 1", ifa.dec_ready_o); else n_pass++;
    tick();
    ifa.wb_valid_i = 0; ifa.dec_valid_i = 0; ifa.rs1_i = 0;
    n_checks++; if (ifa.op_valid_o !== 1'b1 || ifa.ra_o !== 32'h1234) $display("FAIL byp_forward got v=%b ra=%h want v=1 ra=00001234", ifa.op_valid_o, ifa.ra_o); else n_pass++;
    n_checks++; if (ifa.busy_o !== 32'h0) $display("FAIL byp_busy_clr got %h want 0", ifa.busy_o); else n_pass++;
  endtask

  task automatic test_raw_no_bypass();
    ifb.dec_valid_i = 1; ifb.rs1_i = 0; ifb.rs2_i = 0; ifb.rd_i = 3; ifb.rd_we_i = 1;
    tick();
    ifb.rs1_i = 3; ifb.rd_i = 0; ifb.rd_we_i = 0;
    tick();
    ifb.wb_valid_i = 1; ifb.wb_rd_i = 3; ifb.wb_data_i = 32'h1234;
    #1;
    n_checks++; if (ifb.dec_ready_o !== 1'b0) $display("FAIL nobyp_stall_on_wb got %b want 0", ifb.dec_ready_o); else n_pass++;
    tick();
    ifb.wb_valid_i = 0;
    #1;
    n_checks++; if (ifb.op_valid_o !== 1'b0 || ifb.dec_ready_o !== 1'b1) $display("FAIL nobyp_ready_after got v=%b rdy=%b want v=0 rdy=1", ifb.op_valid_o, ifb.dec_ready_o); else n_pass++;
    tick();
    ifb.dec_valid_i = 0; ifb.rs1_i = 0;
    n_checks++; if (ifb.op_valid_o !== 1'b1 || ifb.ra_o !== 32'h1234) $display("FAIL nobyp_operand got v=%b ra=%h want v=1 ra=00001234", ifb.op_valid_o, ifb.ra_o); else n_pass++;
  endtask

  task automatic test_waw();
    ifa.dec_valid_i = 1; ifa.rs1_i = 0; ifa.rs2_i = 0; ifa.rd_i = 7; ifa.rd_we_i = 1;
    tick();
    #1;
    n_checks++; if (ifa.dec_ready_o !== 1'b0) $display("FAIL waw_stall got %b want 0", ifa.dec_ready_o); else n_pass++;
    tick();
    n_checks++; if (ifa.op_valid_o !== 1'b0) $display("FAIL waw_no_issue got %b want 0", ifa.op_valid_o); else n_pass++;
    ifa.wb_valid_i = 1; ifa.wb_rd_i = 7; ifa.wb_data_i = 32'hCAFE0007;
    #1;
    n_checks++; if (ifa.dec_ready_o !== 1'b1) $display("FAIL waw_release got %b want 1", ifa.dec_ready_o); else n_pass++;
    tick();
    ifa.wb_valid_i = 0; ifa.dec_valid_i = 0; ifa.rd_we_i = 0; ifa.rd_i = 0;
    n_checks++; if (ifa.busy_o !== 32'h80) $display("FAIL waw_set_wins got %h want 00000080", ifa.busy_o); else n_pass++;
    n_checks++; if (ifa.op_valid_o !== 1'b1 || ifa.op_rd_o !== 5'd7) $display("FAIL waw_issue got v=%b rd=%0d want v=1 rd=7", ifa.op_valid_o, ifa.op_rd_o); else n_pass++;
  endtask

  task automatic test_wb_not_busy();
    ifa.wb_valid_i = 1; ifa.wb_rd_i = 9; ifa.wb_data_i = 32'h99;
    tick();
    ifa.wb_valid_i = 0;
    n_checks++; if (ifa.busy_o !== 32'h80) $display("FAIL nb_busy_kept got %h want 00000080", ifa.busy_o); else n_pass++;
    ifa.dec_valid_i = 1; ifa.rs1_i = 9; ifa.rs2_i = 0;
    tick();
    ifa.dec_valid_i = 0; ifa.rs1_i = 0;
    n_checks++; if (ifa.ra_o !== 32'h99 || ifa.op_rd_o !== 5'd0) $display("FAIL nb_read got ra=%h rd=%0d want ra=00000099 rd=0", ifa.ra_o, ifa.op_rd_o); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    ifa.dec_valid_i = 1; ifa.rd_i = 2; ifa.rd_we_i = 1;
    tick();
    n_checks++; if (ifa.busy_o !== 32'h84) $display("FAIL mid_busy got %h want 00000084", ifa.busy_o); else n_pass++;
    ifa.rs1_i = 2; ifa.rd_i = 0; ifa.rd_we_i = 0;
    reset = 1;
    tick();
    n_checks++; if (ifa.busy_o !== 32'h0 || ifa.ra_o !== 32'h0) $display("FAIL mid_clear got busy=%h ra=%h want 0/0", ifa.busy_o, ifa.ra_o); else n_pass++;
    n_checks++; if (ifa.op_valid_o !== 1'b0 || ifa.dec_ready_o !== 1'b1) $display("FAIL mid_ctrl got v=%b rdy=%b want v=0 rdy=1", ifa.op_valid_o, ifa.dec_ready_o); else n_pass++;
    reset = 0;
    ifa.dec_valid_i = 0; ifa.rs1_i = 0;
    ifa.wb_valid_i = 1; ifa.wb_rd_i = 4; ifa.wb_data_i = 32'h44;
    tick();
    ifa.wb_valid_i = 0;
    ifa.dec_valid_i = 1; ifa.rs1_i = 4; ifa.rs2_i = 9;
    tick();
    ifa.dec_valid_i = 0;
    n_checks++; if (ifa.ra_o !== 32'h44 || ifa.rb_o !== 32'h0) $display("FAIL mid_after got ra=%h rb=%h want 00000044/0", ifa.ra_o, ifa.rb_o); else n_pass++;
  endtask

  task automatic test_narrow();
    ifc.wb_valid_i = 1; ifc.wb_rd_i = 7; ifc.wb_data_i = 16'hFFFF;
    tick();
    ifc.wb_valid_i = 0;
    // 9 aliases to index 1 on a 3-bit port; r1 was never written.
    ifc.dec_valid_i = 1; ifc.rs1_i = 7; ifc.rs2_i = 3'(4'd9);
    #1;
    n_checks++; if (ifc.dec_ready_o !== 1'b1) $display("FAIL narrow_ready got %b want 1", ifc.dec_ready_o); else n_pass++;
    tick();
    ifc.dec_valid_i = 0;
    n_checks++; if (ifc.ra_o !== 16'hFFFF || ifc.rb_o !== 16'h0) $display("FAIL narrow_read got %h/%h want ffff/0000", ifc.ra_o, ifc.rb_o); else n_pass++;
    n_checks++; if (ifc.busy_o !== 8'h0 || ifc.op_valid_o !== 1'b1) $display("FAIL narrow_state got busy=%h v=%b want 00/1", ifc.busy_o, ifc.op_valid_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r0_write();
    test_raw_bypass();
    test_raw_no_bypass();
    test_waw();
    test_wb_not_busy();
    test_reset_mid_op();
    test_narrow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
